// File: rtl/aes_inv_cipher.sv
// Iterative AES-128 decryptor: one inverse round per clock. The last round key is
// expanded once per key load, and earlier round keys are regenerated backwards
// on the fly while a block is being decrypted.

package aes_inv_cipher_pkg;

  // GF(2^8) multiply, modulus x^8+x^4+x^3+x+1 (0x11B)
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0)
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

endpackage

// Forward S-box: field inverse followed by the affine transform
module aes_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import aes_inv_cipher_pkg::*;
  logic [7:0] w_inv;
  assign w_inv = gf_inv(i_a);
  assign o_s   = w_inv ^ {w_inv[6:0], w_inv[7]} ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]} ^ {w_inv[3:0], w_inv[7:4]} ^ 8'h63;
endmodule

// Inverse S-box: inverse affine transform followed by the field inverse
module aes_inv_sbox (
  input  logic [7:0] i_a,
  output logic [7:0] o_s
);
  import aes_inv_cipher_pkg::*;
  logic [7:0] w_aff;
  assign w_aff = {i_a[6:0], i_a[7]} ^ {i_a[4:0], i_a[7:5]} ^ {i_a[1:0], i_a[7:2]} ^ 8'h05;
  assign o_s   = gf_inv(w_aff);
endmodule

module aes_inv_cipher #(
  parameter int unsigned KEY_LEN       = 128,
  parameter int unsigned DATA_LEN      = 128,
  parameter int unsigned NUMS_OF_ROUND = 10
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid_in,
  input  logic [KEY_LEN-1:0]  cipher_key,
  input  logic                data_valid_in,
  input  logic [DATA_LEN-1:0] cipher_text,
  output logic                data_ready_out,
  output logic                key_ready_out,
  output logic                data_valid_out,
  output logic [DATA_LEN-1:0] plain_text
);
  import aes_inv_cipher_pkg::*;

  localparam int unsigned BLK_W = 128;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_KEY_EXP, S_READY, S_ROUND} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [BLK_W-1:0] r_rk10;
  logic [BLK_W-1:0] r_wkey;
  logic [BLK_W-1:0] r_blk;
  logic             w_data_ready_nxt;
  logic             w_key_ready_nxt;
  logic             w_valid_nxt;

  logic [7:0]       w_rcon;
  logic [31:0]      w_sb_in;
  logic [31:0]      w_rot;
  logic [31:0]      w_sub;
  logic [BLK_W-1:0] w_fwd_key;
  logic [BLK_W-1:0] w_bk_key;
  logic [BLK_W-1:0] w_isr;
  logic [BLK_W-1:0] w_isb;
  logic [BLK_W-1:0] w_imc;

  // Round constant for the key step indexed by the counter
  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] idx);
    logic [7:0] v;
    case (idx)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Row r of the state rotates right by r columns
  function automatic logic [BLK_W-1:0] inv_shift_rows(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return y;
  endfunction

  // Column mix with coefficients {0e,0b,0d,09}
  function automatic logic [BLK_W-1:0] inv_mix_columns(input logic [BLK_W-1:0] x);
    logic [BLK_W-1:0] y;
    logic [7:0] a0, a1, a2, a3;
    y = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = x[127-32*c -: 8];
      a1 = x[119-32*c -: 8];
      a2 = x[111-32*c -: 8];
      a3 = x[103-32*c -: 8];
      y[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      y[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      y[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      y[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return y;
  endfunction

  // Shared SubWord(RotWord()) input: forward uses old w3, backward uses regenerated w3
  assign w_rcon  = rcon(r_cnt);
  assign w_sb_in = (r_state == S_KEY_EXP) ? r_rk10[31:0] : (r_wkey[31:0] ^ r_wkey[63:32]);
  assign w_rot   = {w_sb_in[23:0], w_sb_in[31:24]};

  genvar g;
  for (g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (.i_a(w_rot[31-8*g -: 8]), .o_s(w_sub[31-8*g -: 8]));
  end

  // Forward key step rk_i from rk_{i-1}
  always_comb begin
    w_fwd_key[127:96] = r_rk10[127:96] ^ w_sub ^ {w_rcon, 24'h000000};
    w_fwd_key[95:64]  = r_rk10[95:64] ^ w_fwd_key[127:96];
    w_fwd_key[63:32]  = r_rk10[63:32] ^ w_fwd_key[95:64];
    w_fwd_key[31:0]   = r_rk10[31:0]  ^ w_fwd_key[63:32];
  end

  // Backward key step rk_r from rk_{r+1}
  always_comb begin
    w_bk_key[31:0]   = r_wkey[31:0]  ^ r_wkey[63:32];
    w_bk_key[63:32]  = r_wkey[63:32] ^ r_wkey[95:64];
    w_bk_key[95:64]  = r_wkey[95:64] ^ r_wkey[127:96];
    w_bk_key[127:96] = r_wkey[127:96] ^ w_sub ^ {w_rcon, 24'h000000};
  end

  assign w_isr = inv_shift_rows(r_blk);

  for (g = 0; g < 16; g++) begin : g_inv_sbox
    aes_inv_sbox u_inv_sbox (.i_a(w_isr[127-8*g -: 8]), .o_s(w_isb[127-8*g -: 8]));
  end

  assign w_imc = inv_mix_columns(w_isb ^ w_bk_key);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic; key load has priority over data in READY
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (key_valid_in) w_state_nxt = S_KEY_EXP;
      S_KEY_EXP: if (r_cnt == CNT_W'(NUMS_OF_ROUND)) w_state_nxt = S_READY;
      S_READY: begin
        if (key_valid_in)       w_state_nxt = S_KEY_EXP;
        else if (data_valid_in) w_state_nxt = S_ROUND;
      end
      S_ROUND:   if (r_cnt == CNT_W'(1)) w_state_nxt = S_READY;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode, registered below
  always_comb begin
    w_data_ready_nxt = 1'b0;
    w_key_ready_nxt  = 1'b0;
    w_valid_nxt      = 1'b0;
    if (w_state_nxt == S_READY) w_data_ready_nxt = 1'b1;
    if (w_state_nxt == S_READY || w_state_nxt == S_ROUND) w_key_ready_nxt = 1'b1;
    if (r_state == S_ROUND && r_cnt == CNT_W'(1)) w_valid_nxt = 1'b1;
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt          <= '0;
      r_rk10         <= '0;
      r_wkey         <= '0;
      r_blk          <= '0;
      plain_text     <= '0;
      data_ready_out <= 1'b0;
      key_ready_out  <= 1'b0;
      data_valid_out <= 1'b0;
    end else begin
      data_ready_out <= w_data_ready_nxt;
      key_ready_out  <= w_key_ready_nxt;
      data_valid_out <= w_valid_nxt;
      case (r_state)
        S_IDLE: begin
          if (key_valid_in) begin
            r_rk10 <= BLK_W'(cipher_key);
            r_cnt  <= CNT_W'(1);
          end
        end
        S_KEY_EXP: begin
          r_rk10 <= w_fwd_key;
          r_cnt  <= CNT_W'(r_cnt + CNT_W'(1));
        end
        S_READY: begin
          if (key_valid_in) begin
            r_rk10 <= BLK_W'(cipher_key);
            r_cnt  <= CNT_W'(1);
          end else if (data_valid_in) begin
            r_blk  <= BLK_W'(cipher_text) ^ r_rk10;
            r_wkey <= r_rk10;
            r_cnt  <= CNT_W'(NUMS_OF_ROUND);
          end
        end
        S_ROUND: begin
          r_wkey <= w_bk_key;
          r_cnt  <= CNT_W'(r_cnt - CNT_W'(1));
          if (r_cnt == CNT_W'(1)) plain_text <= DATA_LEN'(w_isb ^ w_bk_key);
          else                    r_blk      <= w_imc;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// Self-checking bench for aes_inv_cipher against an AES-128 encryption model.
module tb_aes_inv_cipher;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         key_valid_in = 1'b0;
  logic [127:0] cipher_key = '0;
  logic         data_valid_in = 1'b0;
  logic [127:0] cipher_text = '0;
  logic         data_ready_out;
  logic         key_ready_out;
  logic         data_valid_out;
  logic [127:0] plain_text;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0]   sbox [256];
  logic [127:0] m_rk [11];

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KEY2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;

  aes_inv_cipher dut (
    .clk(clk), .reset(reset), .key_valid_in(key_valid_in), .cipher_key(cipher_key),
    .data_valid_in(data_valid_in), .cipher_text(cipher_text), .data_ready_out(data_ready_out),
    .key_ready_out(key_ready_out), .data_valid_out(data_valid_out), .plain_text(plain_text)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    while (y != 8'h00) begin
      if (y[0]) p ^= x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box table from a brute-force inverse and the bitwise affine rule
  task automatic build_sbox();
    logic [7:0] inv, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox[x] = s;
    end
  endtask

  task automatic expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] encrypt(input logic [127:0] pt);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] blk;
    blk = pt ^ m_rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[blk[127-8*i -: 8]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
          s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
          s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
          s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
      end
      for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = s[i];
      blk ^= m_rk[r];
    end
    return blk;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Load a key and check expansion latency and the stored final round key
  task automatic load_key(input string tag, input logic [127:0] key);
    int n;
    cipher_key   = key;
    key_valid_in = 1'b1;
    step();
    key_valid_in = 1'b0;
    n = 0;
    while (!key_ready_out && n < 20) begin
      step();
      n++;
    end
    check({tag, "_key_latency"}, 128'(n), 128'd10);
    expand(key);
    check({tag, "_rk10"}, dut.r_rk10, m_rk[10]);
  endtask

  // Decrypt one block, checking latency, result, pulse width and hold
  task automatic decrypt(input string tag, input logic [127:0] ct, input logic [127:0] exp);
    int n;
    n = 0;
    while (!data_ready_out && n < 40) begin
      step();
      n++;
    end
    check({tag, "_ready"}, 128'(data_ready_out), 128'd1);
    cipher_text   = ct;
    data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
    check({tag, "_busy"}, 128'(data_ready_out), 128'd0);
    n = 0;
    while (!data_valid_out && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'd10);
    check({tag, "_pt"}, plain_text, exp);
    check({tag, "_ready_with_valid"}, 128'(data_ready_out), 128'd1);
    step();
    check({tag, "_pulse_end"}, 128'(data_valid_out), 128'd0);
    check({tag, "_pt_hold"}, plain_text, exp);
  endtask

  initial begin
    logic [127:0] q_ct [$];
    logic [127:0] q_pt [$];
    logic [127:0] pt, ct, k;
    int idx, got, last_cyc, n_valid, first_valid;
    logic acc;

    build_sbox();

    // Test 1: reset and key expansion
    reset = 1'b0;
    repeat (3) step();
    check("rst_flags", 128'({data_ready_out, key_ready_out, data_valid_out}), 128'd0);
    check("rst_pt", plain_text, 128'd0);
    reset = 1'b1;
    step();
    load_key("t1", KEY1);
    check("t1_rk10_const", dut.r_rk10, 128'h13111d7fe3944a17f307a78b4d2b30c5);

    // Test 2: known vector
    decrypt("t2", CT1, PT1);

    // Test 3: second known key and vector
    load_key("t3", KEY2);
    decrypt("t3", CT2, PT2);

    // Test 4: data_valid_in held high, back-to-back blocks
    load_key("t4", KEY1);
    q_ct.delete(); q_pt.delete();
    for (int i = 0; i < 4; i++) begin
      pt = (i % 2 == 0) ? PT1 : rand128();
      q_pt.push_back(pt);
      q_ct.push_back(encrypt(pt));
    end
    idx = 0; got = 0; last_cyc = 0;
    cipher_text   = q_ct[0];
    data_valid_in = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      acc = data_ready_out && data_valid_in;
      step();
      if (acc) begin
        idx++;
        if (idx < q_ct.size()) cipher_text = q_ct[idx];
        else data_valid_in = 1'b0;
      end
      if (data_valid_out) begin
        if (got < q_pt.size()) check($sformatf("t4_pt%0d", got), plain_text, q_pt[got]);
        if (got > 0) check($sformatf("t4_period%0d", got), 128'(cyc - last_cyc), 128'd11);
        last_cyc = cyc;
        got++;
      end
    end
    data_valid_in = 1'b0;
    check("t4_count", 128'(got), 128'(q_pt.size()));

    // Test 5a: key and data together in READY, data pulses during KEY_EXP
    k = rand128();
    cipher_key    = k;
    cipher_text   = rand128();
    key_valid_in  = 1'b1;
    data_valid_in = 1'b1;
    step();
    key_valid_in = 1'b0;
    check("t5_no_accept", 128'(data_ready_out), 128'd0);
    check("t5_key_busy", 128'(key_ready_out), 128'd0);
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      data_valid_in = 1'($urandom);
      cipher_text   = rand128();
      step();
      if (data_valid_out) n_valid++;
    end
    data_valid_in = 1'b0;
    step();
    if (data_valid_out) n_valid++;
    check("t5_key_not_yet", 128'(key_ready_out), 128'd0);
    step();
    check("t5_key_ready", 128'(key_ready_out), 128'd1);
    check("t5_no_valid_exp", 128'(n_valid), 128'd0);
    expand(k);
    check("t5_rk10", dut.r_rk10, m_rk[10]);

    // Test 5b: pulses on both valids during ROUND are ignored
    pt = rand128();
    cipher_text   = encrypt(pt);
    data_valid_in = 1'b1;
    step();
    n_valid = 0; first_valid = 0;
    for (int i = 1; i <= 25; i++) begin
      if (i <= 8) begin
        data_valid_in = 1'($urandom);
        key_valid_in  = 1'($urandom);
        cipher_text   = rand128();
        cipher_key    = rand128();
      end else begin
        data_valid_in = 1'b0;
        key_valid_in  = 1'b0;
      end
      step();
      if (data_valid_out) begin
        n_valid++;
        if (first_valid == 0) begin
          first_valid = i;
          check("t5_round_pt", plain_text, pt);
        end
      end
    end
    check("t5_round_count", 128'(n_valid), 128'd1);
    check("t5_round_latency", 128'(first_valid), 128'd10);
    check("t5_rk10_kept", dut.r_rk10, m_rk[10]);

    // Test 6: reset at E5 aborts the decryption
    pt = rand128();
    cipher_text   = encrypt(pt);
    data_valid_in = 1'b1;
    step();
    data_valid_in = 1'b0;
    repeat (4) step();
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("t6_flags", 128'({data_ready_out, key_ready_out, data_valid_out}), 128'd0);
    check("t6_pt", plain_text, 128'd0);
    n_valid = 0;
    data_valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (data_valid_out) n_valid++;
    end
    data_valid_in = 1'b0;
    check("t6_no_valid", 128'(n_valid), 128'd0);
    check("t6_needs_key", 128'({data_ready_out, key_ready_out}), 128'd0);

    // Random keys and blocks
    for (int i = 0; i < 4; i++) begin
      k = rand128();
      load_key($sformatf("rnd%0d", i), k);
      for (int j = 0; j < 2; j++) begin
        pt = rand128();
        decrypt($sformatf("rnd%0d_%0d", i, j), encrypt(pt), pt);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
